// File: rtl/test_result_reader.sv
// test_result_reader
// Streams the eight PUF NIST per-test pass counters from the result BRAM to
// the SIRC/PC handler over a valid/ready byte interface and builds a pass
// mask against PASS_THRESHOLD while the bytes go out.
// Optional feature: define RESULT_CHECKSUM_EN to append a ninth byte holding
// the XOR of the eight counters (that byte alone carries out_last).
module test_result_reader #(
  parameter int         ADDR_WIDTH     = 13,
  parameter int         BASE_ADDR      = 1,
  parameter int         N_RESULTS      = 8,
  parameter logic [7:0] PASS_THRESHOLD = 8'd250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  test_done,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [7:0]            mem_dout,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [N_RESULTS-1:0]  pass_mask,
  output logic                  busy,
  output logic                  read_done
);

  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [2:0]            LAST_IDX = 3'(N_RESULTS - 1);

`ifdef RESULT_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_HOLD, S_CHK, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DONE
  } state_t;
`endif

  state_t     state;
  logic [2:0] idx;
  logic [2:0] idx_next;
  logic       s1;
  logic       s2;
  logic       s2_d;
  logic       start;
`ifdef RESULT_CHECKSUM_EN
  logic [7:0] chk;
`endif

  // Rising edge of the synchronized test_done level starts a frame.
  assign start    = s2 & ~s2_d;
  assign idx_next = idx + 3'd1;

  // Synchronizer, frame sequencer and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= 3'd0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s2_d      <= 1'b0;
      mem_re    <= 1'b0;
      mem_raddr <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_last  <= 1'b0;
      pass_mask <= '0;
      busy      <= 1'b0;
      read_done <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
      chk       <= 8'd0;
`endif
    end else begin
      s1   <= test_done;
      s2   <= s1;
      s2_d <= s2;
      case (state)
        S_IDLE: begin
          idx <= 3'd0;
          if (start) begin
            pass_mask <= '0;
`ifdef RESULT_CHECKSUM_EN
            chk       <= 8'd0;
`endif
            mem_re    <= 1'b1;
            mem_raddr <= BASE;
            busy      <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          mem_re <= 1'b0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          out_data  <= mem_dout;
          out_valid <= 1'b1;
`ifdef RESULT_CHECKSUM_EN
          out_last  <= 1'b0;
`else
          out_last  <= (idx == LAST_IDX);
`endif
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            pass_mask[idx] <= (out_data >= PASS_THRESHOLD);
`ifdef RESULT_CHECKSUM_EN
            chk <= chk ^ out_data;
`endif
            if (idx == LAST_IDX) begin
`ifdef RESULT_CHECKSUM_EN
              out_data  <= chk ^ out_data;
              out_valid <= 1'b1;
              out_last  <= 1'b1;
              state     <= S_CHK;
`else
              out_valid <= 1'b0;
              busy      <= 1'b0;
              read_done <= 1'b1;
              state     <= S_DONE;
`endif
            end else begin
              out_valid <= 1'b0;
              idx       <= idx_next;
              mem_re    <= 1'b1;
              mem_raddr <= BASE + ADDR_WIDTH'(idx_next);
              state     <= S_REQ;
            end
          end
        end
`ifdef RESULT_CHECKSUM_EN
        S_CHK: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            read_done <= 1'b1;
            state     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (!s2) begin
            read_done <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_result_reader.sv
// Testbench for test_result_reader: a behavioural frame model (expected byte
// and address queues, threshold mask, XOR checksum) is checked against the DUT
// every cycle, with directed scenarios plus randomized data and back-pressure.
// Honours RESULT_CHECKSUM_EN the same way the design does.
module tb_test_result_reader;

  localparam int         AW     = 13;
  localparam int         BASE   = 1;
  localparam logic [7:0] THRESH = 8'd250;
`ifdef RESULT_CHECKSUM_EN
  localparam int         CHK_EXTRA = 1;
`else
  localparam int         CHK_EXTRA = 0;
`endif

  logic          clk;
  logic          rst;
  logic          test_done;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic [7:0]    mem_dout;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_last;
  logic          out_ready;
  logic [7:0]    pass_mask;
  logic          busy;
  logic          read_done;

  logic [7:0]    mem_model [0:15];
  logic [7:0]    exp_q [$];
  logic [AW-1:0] addr_q [$];
  logic [7:0]    model_mask;
  int            frame_len;
  int            assert_count;
  int            fail_count;
  logic          prev_valid;
  logic          prev_accept;
  logic [7:0]    prev_data;
  logic          prev_last;
  logic [7:0]    last_acc_data;

  test_result_reader #(
    .ADDR_WIDTH(AW),
    .BASE_ADDR(BASE),
    .N_RESULTS(8),
    .PASS_THRESHOLD(THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .test_done(test_done),
    .mem_re(mem_re),
    .mem_raddr(mem_raddr),
    .mem_dout(mem_dout),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last),
    .out_ready(out_ready),
    .pass_mask(pass_mask),
    .busy(busy),
    .read_done(read_done)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Result BRAM: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_re) mem_dout <= (mem_raddr < 16) ? mem_model[mem_raddr[3:0]] : 8'h00;
  end

  // Global time bound so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportFail(input string name);
    assert_count++;
    fail_count++;
    $display("[TB] FAIL %s: got unexpected event expected none at %0t", name, $time);
  endtask

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic       acc;
    logic [7:0] e;
    if (rst) begin
      prev_valid  = 1'b0;
      prev_accept = 1'b0;
    end else begin
      if (prev_valid && !prev_accept) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_data", out_data, prev_data);
        checkOutput("hold_last", out_last, prev_last);
      end
      if (mem_re) begin
        if (addr_q.size() == 0) reportFail("extra_mem_re");
        else checkOutput("mem_raddr", mem_raddr, addr_q.pop_front());
      end
      acc = out_valid && out_ready;
      if (acc) begin
        if (exp_q.size() == 0) reportFail("extra_byte");
        else begin
          e = exp_q.pop_front();
          checkOutput("out_data", out_data, e);
          checkOutput("out_last", out_last, (exp_q.size() == 0) ? 1 : 0);
          last_acc_data = out_data;
        end
      end
      prev_valid  = out_valid;
      prev_data   = out_data;
      prev_last   = out_last;
      prev_accept = acc;
    end
  end

  task automatic loadFixed();
    logic [7:0] vals [0:7];
    vals = '{8'd255, 8'd250, 8'd249, 8'd0, 8'd128, 8'd251, 8'd254, 8'd100};
    for (int i = 0; i < 8; i++) mem_model[BASE+i] = vals[i];
  endtask

  task automatic loadRandom();
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0:       mem_model[BASE+i] = 8'(249 + $urandom_range(0, 2));
        default: mem_model[BASE+i] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  // One frame: build the model, pulse test_done and drive out_ready.
  task automatic applyStimulus(input int ready_mode, input int stall_byte, input int stall_len,
                               input int drop_byte, input int rst_byte, input bit pin_literals);
    int         k;
    int         cur;
    int         first_valid;
    int         first_done;
    int         stall_left;
    int         cnt;
    bit         aborted;
    logic [7:0] chk;
    exp_q.delete();
    addr_q.delete();
    chk        = 8'd0;
    model_mask = 8'd0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mem_model[BASE+i]);
      addr_q.push_back(AW'(BASE + i));
      chk = chk ^ mem_model[BASE+i];
      if (mem_model[BASE+i] >= THRESH) model_mask[i] = 1'b1;
    end
`ifdef RESULT_CHECKSUM_EN
    exp_q.push_back(chk);
`endif
    frame_len = exp_q.size();
    @(posedge clk); #1;
    out_ready   = (ready_mode == 0);
    test_done   = 1'b1;
    k           = -1;
    first_valid = -1;
    first_done  = -1;
    stall_left  = stall_len;
    aborted     = 1'b0;
    while (!read_done && k < 400 && !aborted) begin
      @(posedge clk); #1;
      k++;
      cur = frame_len - exp_q.size();
      if (out_valid && first_valid < 0) first_valid = k;
      if (k == 3) checkOutput("mask_cleared", pass_mask, 0);
      if (read_done) first_done = k;
      if (rst_byte >= 0 && out_valid && cur == rst_byte) begin
        rst       = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_mem_re", mem_re, 0);
        checkOutput("rst_mem_raddr", mem_raddr, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_pass_mask", pass_mask, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_read_done", read_done, 0);
        test_done = 1'b0;
        rst       = 1'b0;
        exp_q.delete();
        addr_q.delete();
        aborted = 1'b1;
      end else begin
        if (drop_byte >= 0 && cur == drop_byte) test_done = 1'b0;
        if (stall_byte >= 0 && out_valid && cur == stall_byte && stall_left > 0) begin
          checkOutput("stall_data", out_data, 8'd249);
          out_ready  = 1'b0;
          stall_left--;
        end else if (ready_mode == 0) out_ready = 1'b1;
        else out_ready = 1'($urandom_range(0, 1));
      end
    end
    if (aborted) begin
      repeat (3) @(posedge clk);
      #1;
      return;
    end
    if (!read_done) reportFail("frame_timeout");
    checkOutput("pass_mask", pass_mask, model_mask);
    checkOutput("bytes_left", exp_q.size(), 0);
    checkOutput("reads_left", addr_q.size(), 0);
    checkOutput("busy_done", busy, 0);
    if (pin_literals) begin
      checkOutput("first_valid_latency", first_valid, 4);
      checkOutput("frame_cycles", first_done, 26 + CHK_EXTRA);
      checkOutput("pass_mask_literal", pass_mask, 8'h63);
`ifdef RESULT_CHECKSUM_EN
      checkOutput("checksum_literal", last_acc_data, 8'h1D);
`else
      checkOutput("last_byte_literal", last_acc_data, 8'd100);
`endif
    end
    if (drop_byte >= 0) begin
      cnt = 1;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (!read_done) break;
        cnt++;
      end
      checkOutput("done_cycles_after_drop", cnt, 1);
    end else begin
      repeat (10) @(posedge clk);
      #1;
      checkOutput("done_held", read_done, 1);
      checkOutput("no_refire", out_valid, 0);
      test_done = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (!read_done) break;
        cnt++;
      end
      checkOutput("done_exit_cycles", cnt, 2);
    end
    test_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Test sequence: reset values, directed scenarios, then random frames.
  initial begin
    assert_count = 0;
    fail_count   = 0;
    rst          = 1'b1;
    test_done    = 1'b0;
    out_ready    = 1'b0;
    prev_valid   = 1'b0;
    prev_accept  = 1'b0;
    for (int i = 0; i < 16; i++) mem_model[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_mem_re", mem_re, 0);
    checkOutput("reset_mem_raddr", mem_raddr, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_last", out_last, 0);
    checkOutput("reset_pass_mask", pass_mask, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_read_done", read_done, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] fixed frame, ready tied high");
    loadFixed();
    applyStimulus(0, -1, 0, -1, -1, 1'b1);
    $display("[TB] second identical frame");
    applyStimulus(0, -1, 0, -1, -1, 1'b1);
    $display("[TB] stall on byte 3");
    applyStimulus(0, 2, 5, -1, -1, 1'b0);
    $display("[TB] test_done dropped during byte 4");
    applyStimulus(0, -1, 0, 3, -1, 1'b0);
    $display("[TB] reset during byte 5");
    applyStimulus(0, -1, 0, -1, 4, 1'b0);
    $display("[TB] frame after reset");
    applyStimulus(0, -1, 0, -1, -1, 1'b1);

    for (int f = 0; f < 8; f++) begin
      $display("[TB] random frame %0d", f);
      loadRandom();
      applyStimulus(1, -1, 0, -1, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/test_result_reader.md
# test_result_reader

Reads the eight per-test pass counters that the PUF NIST test FSM writes into the result BRAM and streams them to the SIRC/PC handler over a valid/ready byte interface. It waits for the test FSM's `test_done` and issues one BRAM read per counter. Each byte is held on the output until the consumer accepts it. While streaming, it builds a per-test pass mask against a configurable threshold. It sits between the result memory read port and the SIRC output logic, in the `clk` (SIRC) domain.

## Interface

Parameters:
- `ADDR_WIDTH`, 13: result memory address width.
- `BASE_ADDR`, 1: address of the first counter (test1). Counters occupy `BASE_ADDR`..`BASE_ADDR+7`.
- `N_RESULTS`, 8: number of counters. Fixed to 8; `pass_mask` width depends on it.
- `PASS_THRESHOLD`, 8'd250: a counter value >= this sets its `pass_mask` bit.

Ports:
- `clk`, in, 1: SIRC-side clock; all logic is on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `test_done`, in, 1: level from the test FSM (clock domain `clk_1`); synchronized internally.
- `mem_re`, out, 1: read enable to the result BRAM.
- `mem_raddr`, out, ADDR_WIDTH: read address.
- `mem_dout`, in, 8: read data, valid one cycle after the `mem_re` cycle.
- `out_valid`, out, 1: `out_data` is valid.
- `out_data`, out, 8: result byte.
- `out_last`, out, 1: marks the final byte of a frame.
- `out_ready`, in, 1: consumer accepts the byte.
- `pass_mask`, out, 8: bit i = counter i >= `PASS_THRESHOLD`. Updated on each accept.
- `busy`, out, 1: high in any state other than IDLE and DONE.
- `read_done`, out, 1: high in DONE.

## Operation

- `test_done` passes through a 2-flop synchronizer (`s1`, `s2`) plus a delay flop `s2_d`. Start condition is `start = s2 & ~s2_d`.
- States are IDLE, REQ, WAIT, HOLD, DONE, and CHK when the checksum feature is compiled in.
- IDLE:
  - `idx` <= 0; `pass_mask` holds its last value.
  - On `start`: `pass_mask` <= 0, then go to REQ.
- REQ: `mem_re` = 1 and `mem_raddr` = `BASE_ADDR + idx` for one cycle; go to WAIT.
- WAIT: `out_data` <= `mem_dout`, `out_valid` <= 1, `out_last` <= (`idx`==7 and no checksum); go to HOLD.
- HOLD:
  - `out_data`, `out_valid` and `out_last` stay stable while `out_ready`=0.
  - On `out_ready`=1: `out_valid` <= 0, `pass_mask[idx]` <= (`out_data` >= `PASS_THRESHOLD`, 8-bit unsigned compare), and the checksum XOR-accumulates `out_data`.
  - If `idx`==7, go to CHK (or DONE without the checksum); otherwise `idx` <= `idx`+1 and go to REQ.
- CHK: presents the checksum byte with `out_last`=1 under the same valid/ready rule, then goes to DONE.
- DONE:
  - `read_done`=1.
  - When `s2`=0 (test FSM re-armed), go to IDLE.
  - A new frame never starts without a fresh rising edge of `test_done`.
- `test_done` falling during a transfer is ignored: the frame completes, and DONE then exits to IDLE on the next cycle.
- `mem_raddr` arithmetic is ADDR_WIDTH-bit and wraps modulo 2^ADDR_WIDTH.
- `idx` is 3-bit.

## Timing

- Reset values:
  - `mem_re`=0, `mem_raddr`=0
  - `out_valid`=0, `out_data`=0, `out_last`=0
  - `pass_mask`=0, `busy`=0, `read_done`=0
  - state=IDLE, synchronizer flops=0, checksum=0
- `rst` asserted mid-frame aborts immediately. There is no partial completion; the next frame restarts at `BASE_ADDR`.
- `test_done` is first sampled high at edge 0. `start` fires after edge 1, REQ is entered at edge 2, and `out_valid` rises at edge 4.
- With `out_ready` held high, each byte takes 3 cycles (REQ, WAIT, HOLD). The 8-byte frame completes 24 cycles after REQ is first entered.
- `out_valid` never drops without an accept.
- `mem_re` is high exactly one cycle per byte.

## Configuration

- `RESULT_CHECKSUM_EN` defined:
  - After the 8 counters, a 9th byte equal to the XOR of all 8 counters is sent; it alone carries `out_last`=1.
  - It does not affect `pass_mask`.
- Undefined: the CHK state and checksum register are absent, the frame is 8 bytes, and `out_last` is on counter 8.

## Test plan

- Memory 1..8 = 255,250,249,0,128,251,254,100 with `out_ready` tied 1, then pulse `test_done` -> bytes appear in that order, `mem_raddr` runs 1..8, `pass_mask`=0x63, `read_done`=1, and the first `out_valid` is 4 cycles after sampling.
- Same data with `RESULT_CHECKSUM_EN` -> 9th byte 0x1D with `out_last`=1; `out_last`=0 on bytes 1-8.
- `out_ready` low for 5 cycles on byte 3 -> `out_data`=249 stable with `out_valid` high throughout, and no extra `mem_re`.
- `test_done` held high after DONE -> no second frame. Drop it, raise it again -> a second identical frame, with `pass_mask` cleared at start.
- `rst` asserted while in HOLD on byte 5 -> all outputs 0 on the next cycle. A new `test_done` edge restarts from address 1.
- `test_done` dropped during byte 4 -> all 8 bytes still sent, then DONE exits to IDLE after one cycle.
